// File: rtl/grid_renderer.sv
// grid_renderer: two-stage pipeline mapping VGA pixel coordinates to board-cell colours with a frame-latched cursor.
// Optional cursor blinking is built when GRID_RENDERER_CURSOR_BLINK_EN is defined; otherwise the cursor is always visible.
module grid_renderer #(
    parameter int          COLS         = 8,
    parameter int          ROWS         = 8,
    parameter int          STATE_W      = 4,
    parameter int          X_OFF        = 11,
    parameter int          Y_OFF        = 6,
    parameter int          PITCH_X      = 60,
    parameter int          PITCH_Y      = 60,
    parameter int          CELL_W       = 49,
    parameter int          CELL_H       = 49,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] COLOR_BG     = 24'hffffff,
    parameter logic [23:0] COLOR_CUR    = 24'h025e33,
    parameter logic [23:0] COLOR_S0     = 24'h4a004a,
    parameter logic [23:0] COLOR_S1     = 24'hff0000,
    parameter logic [23:0] COLOR_S2     = 24'h0000ff,
    parameter logic [23:0] COLOR_SX     = 24'h4a004a
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic                          pix_valid,
    input  logic                          hsync_i,
    input  logic                          vsync_i,
    input  logic                          frame_tick,
    input  logic [$clog2(COLS)-1:0]       cur_x,
    input  logic [$clog2(ROWS)-1:0]       cur_y,
    input  logic [COLS*ROWS*STATE_W-1:0]  board,
    output logic [23:0]                   color,
    output logic                          pix_valid_o,
    output logic                          hsync_o,
    output logic                          vsync_o
);

    localparam int CX_W = $clog2(COLS);
    localparam int CY_W = $clog2(ROWS);

    if (COLS < 2 || ROWS < 2 || CELL_W > PITCH_X || CELL_H > PITCH_Y || BLINK_FRAMES < 1) begin : g_bad_params
        $error("grid_renderer: illegal parameter combination");
    end

    // Cell bounds are elaborated as 12-bit constants so the comparisons never overflow.
    function automatic logic [11:0] col_lo(input int c);
        return 12'(X_OFF + c * PITCH_X);
    endfunction

    function automatic logic [11:0] col_hi(input int c);
        return 12'(X_OFF + c * PITCH_X + CELL_W - 1);
    endfunction

    function automatic logic [11:0] row_lo(input int r);
        return 12'(Y_OFF + r * PITCH_Y);
    endfunction

    function automatic logic [11:0] row_hi(input int r);
        return 12'(Y_OFF + r * PITCH_Y + CELL_H - 1);
    endfunction

    function automatic logic [23:0] palette(input logic [STATE_W-1:0] s);
        case (int'(s))
            0:       return COLOR_S0;
            1:       return COLOR_S1;
            2:       return COLOR_S2;
            default: return COLOR_SX;
        endcase
    endfunction

    logic [11:0]           x_w;
    logic [11:0]           y_w;
    logic                  col_hit;
    logic                  row_hit;
    logic [CX_W-1:0]       col_idx;
    logic [CY_W-1:0]       row_idx;

    logic                  inside_p1;
    logic [CX_W-1:0]       col_p1;
    logic [CY_W-1:0]       row_p1;
    logic                  vld_p1;
    logic                  hsync_p1;
    logic                  vsync_p1;

    logic [23:0]           color_p2;
    logic                  vld_p2;
    logic                  hsync_p2;
    logic                  vsync_p2;

    logic [CX_W-1:0]       cur_x_lat;
    logic [CY_W-1:0]       cur_y_lat;
    logic                  cur_chg;
    logic                  blink_phase;
    logic                  cur_on;
    logic                  cursor_hit;
    logic [STATE_W-1:0]    cell_state;
    logic [23:0]           color_d;

    assign x_w = {2'b00, x};
    assign y_w = {2'b00, y};

    // Stage 0: one comparator pair per column and per row; cells never overlap.
    always_comb begin
        col_hit = 1'b0;
        col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (x_w >= col_lo(c) && x_w <= col_hi(c)) begin
                col_hit = 1'b1;
                col_idx = CX_W'(c);
            end
        end
    end

    always_comb begin
        row_hit = 1'b0;
        row_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (y_w >= row_lo(r) && y_w <= row_hi(r)) begin
                row_hit = 1'b1;
                row_idx = CY_W'(r);
            end
        end
    end

    // Stage 1: hit flags, cell indices, valid and syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inside_p1 <= 1'b0;
            col_p1    <= '0;
            row_p1    <= '0;
            vld_p1    <= 1'b0;
            hsync_p1  <= 1'b1;
            vsync_p1  <= 1'b1;
        end else begin
            inside_p1 <= col_hit && row_hit;
            col_p1    <= col_idx;
            row_p1    <= row_idx;
            vld_p1    <= pix_valid;
            hsync_p1  <= hsync_i;
            vsync_p1  <= vsync_i;
        end
    end

    // Cursor only moves on frame_tick so it never tears within a frame.
    assign cur_chg = (cur_x != cur_x_lat) || (cur_y != cur_y_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x_lat <= '0;
            cur_y_lat <= '0;
        end else if (frame_tick && cur_chg) begin
            cur_x_lat <= cur_x;
            cur_y_lat <= cur_y;
        end
    end

`ifdef GRID_RENDERER_CURSOR_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] blink_cnt;

    // A moved cursor restarts the blink cycle in the visible phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_tick) begin
            if (cur_chg) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blink_phase = 1'b1;
`endif

    // Board is sampled live here; a mid-frame board write may tear the picture.
    always_comb begin
        cur_on     = blink_phase && (int'(cur_x_lat) < COLS) && (int'(cur_y_lat) < ROWS);
        cursor_hit = cur_on && (col_p1 == cur_x_lat) && (row_p1 == cur_y_lat);
        cell_state = board[(int'(col_p1) * ROWS + int'(row_p1)) * STATE_W +: STATE_W];
        if (!vld_p1) begin
            color_d = 24'h000000;
        end else if (!inside_p1) begin
            color_d = COLOR_BG;
        end else if (cursor_hit) begin
            color_d = COLOR_CUR;
        end else begin
            color_d = palette(cell_state);
        end
    end

    // Stage 2: registered colour and aligned valid/syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_p2 <= 24'h000000;
            vld_p2   <= 1'b0;
            hsync_p2 <= 1'b1;
            vsync_p2 <= 1'b1;
        end else begin
            color_p2 <= color_d;
            vld_p2   <= vld_p1;
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
        end
    end

    assign color       = color_p2;
    assign pix_valid_o = vld_p2;
    assign hsync_o     = hsync_p2;
    assign vsync_o     = vsync_p2;

endmodule

// File: tb/tb_grid_renderer.sv
// Scoreboard bench for grid_renderer: a behavioural board/cursor model predicts each pixel two clocks ahead.
module tb_grid_renderer;

    localparam logic [23:0] C_BG  = 24'hffffff;
    localparam logic [23:0] C_CUR = 24'h025e33;
    localparam logic [23:0] C_S0  = 24'h4a004a;
    localparam logic [23:0] C_S1  = 24'hff0000;
    localparam logic [23:0] C_S2  = 24'h0000ff;
    localparam logic [23:0] C_SX  = 24'h4a004a;
    localparam int          BF    = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [9:0]   x = '0;
    logic [9:0]   y = '0;
    logic         pix_valid = 1'b0;
    logic         hsync_i = 1'b1;
    logic         vsync_i = 1'b1;
    logic         frame_tick = 1'b0;
    logic [2:0]   cur_x = '0;
    logic [2:0]   cur_y = '0;
    logic [255:0] board = '0;
    logic [191:0] board6 = '0;
    logic [23:0]  color, color6;
    logic         pix_valid_o, hsync_o, vsync_o;
    logic         pv6, hs6, vs6;

    grid_renderer #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pix_valid(pix_valid),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .frame_tick(frame_tick),
        .cur_x(cur_x), .cur_y(cur_y), .board(board),
        .color(color), .pix_valid_o(pix_valid_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    grid_renderer #(.COLS(6), .BLINK_FRAMES(BF)) dut6 (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .pix_valid(pix_valid),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .frame_tick(frame_tick),
        .cur_x(cur_x), .cur_y(cur_y), .board(board6),
        .color(color6), .pix_valid_o(pv6), .hsync_o(hs6), .vsync_o(vs6)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [26:0] main;
        logic [23:0] c6;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cx, m_cy, m_cnt;
    bit   m_phase;

    task automatic model_reset();
        m_cx = 0; m_cy = 0; m_cnt = 0; m_phase = 1'b1;
    endtask

    task automatic model_frame();
        if (int'(cur_x) != m_cx || int'(cur_y) != m_cy) begin
            m_cx = int'(cur_x); m_cy = int'(cur_y); m_cnt = 0; m_phase = 1'b1;
        end else begin
`ifdef GRID_RENDERER_CURSOR_BLINK_EN
            if (m_cnt == BF - 1) begin
                m_cnt = 0; m_phase = !m_phase;
            end else begin
                m_cnt = m_cnt + 1;
            end
`endif
        end
    endtask

    function automatic logic [23:0] model_color(input int px, input int py, input bit pv,
                                                input int cols, input logic [255:0] brd);
        int col = -1;
        int row = -1;
        logic [3:0] st;
        if (!pv) return 24'h000000;
        for (int c = 0; c < cols; c++)
            if (px >= 11 + 60 * c && px <= 11 + 60 * c + 48) col = c;
        for (int r = 0; r < 8; r++)
            if (py >= 6 + 60 * r && py <= 6 + 60 * r + 48) row = r;
        if (col < 0 || row < 0) return C_BG;
        if (m_phase && m_cx < cols && m_cy < 8 && col == m_cx && row == m_cy) return C_CUR;
        st = brd[(col * 8 + row) * 4 +: 4];
        case (st)
            4'd0:    return C_S0;
            4'd1:    return C_S1;
            4'd2:    return C_S2;
            default: return C_SX;
        endcase
    endfunction

    task automatic tick(input int px, input int py, input bit pv, input bit hs, input bit vs,
                        input bit ft, output bit have, output exp_t e);
        exp_t ne;
        x = 10'(px); y = 10'(py); pix_valid = pv;
        hsync_i = hs; vsync_i = vs; frame_tick = ft;
        if (ft) model_frame();
        ne.main = {model_color(px, py, pv, 8, board), pv, hs, vs};
        ne.c6   = model_color(px, py, pv, 6, {64'd0, board6});
        sb.push_back(ne);
        @(posedge clk); #1;
        frame_tick = 1'b0;
        have = (sb.size() > 1);
        if (have) e = sb.pop_front();
        else e = '0;
    endtask

    task automatic restart_after_reset();
        exp_t p;
        sb.delete();
        p.main = {24'h000000, 1'b0, 1'b1, 1'b1};
        p.c6 = 24'h000000;
        sb.push_back(p);
        model_reset();
    endtask

    task automatic test_reset();
        bit have; exp_t e;
        int pts[4][2] = '{'{20, 20}, '{80, 20}, '{80, 20}, '{700, 20}};
        rst_n = 1'b0; x = 10'd20; y = 10'd20; pix_valid = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (color !== 24'h0) begin n_err++; $display("FAIL reset_color: got %h want 000000", color); end
        n_cmp++; if (pix_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_pv: got %b want 0", pix_valid_o); end
        n_cmp++; if (hsync_o !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b want 1", hsync_o); end
        n_cmp++; if (vsync_o !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b want 1", vsync_o); end
        rst_n = 1'b1;
        restart_after_reset();
        for (int i = 0; i < 4; i++) begin
            tick(pts[i][0], pts[i][1], i < 3, 1'b1, 1'b1, 1'b0, have, e);
            if (have) begin
                n_cmp++;
                if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                    n_err++; $display("FAIL after_reset[%0d]: got %h want %h", i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                end
            end
        end
    endtask

    task automatic test_cell_mapping();
        bit have; exp_t e;
        int pts[12][2] = '{'{191, 306}, '{190, 306}, '{239, 306}, '{240, 306}, '{191, 305}, '{191, 354},
                           '{191, 355}, '{71, 66}, '{419, 474}, '{500, 500}, '{479, 474}, '{0, 0}};
        board[116 +: 4] = 4'd2;
        board[36 +: 4]  = 4'd1;
        board[220 +: 4] = 4'd5;
        for (int i = 0; i < 14; i++) begin
            if (i < 12) tick(pts[i][0], pts[i][1], 1'b1, 1'b1, 1'b1, 1'b0, have, e);
            else tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, have, e);
            if (have) begin
                n_cmp++;
                if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                    n_err++; $display("FAIL cell_map[%0d]: got %h want %h", i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                end
            end
        end
    endtask

    task automatic test_syncs();
        bit have; exp_t e;
        for (int i = 0; i < 112; i++) begin
            tick(150 + i * 3, 300, (i % 7) != 3 && i < 100, !(i >= 6 && i < 102), !(i >= 40 && i < 44), 1'b0, have, e);
            if (have) begin
                n_cmp++;
                if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                    n_err++; $display("FAIL syncs[%0d]: got %h want %h", i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                end
            end
        end
    endtask

    task automatic test_cursor_latch();
        bit have; exp_t e;
        cur_x = 3'd2; cur_y = 3'd2;
        for (int i = 0; i < 10; i++) begin
            tick(i < 8 ? 141 : 20, i < 8 ? 126 : 20, 1'b1, 1'b1, 1'b1, i == 4, have, e);
            if (have) begin
                n_cmp++;
                if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                    n_err++; $display("FAIL cursor_latch[%0d]: got %h want %h", i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                end
            end
        end
    endtask

    task automatic test_blink();
        bit have; exp_t e;
        for (int f = 1; f <= 8; f++) begin
            if (f == 7) begin cur_x = 3'd4; cur_y = 3'd1; end
            for (int i = 0; i < 5; i++) begin
                if (i == 0) tick(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, have, e);
                else if (i < 3) tick(141, 126, 1'b1, 1'b1, 1'b1, 1'b0, have, e);
                else tick(251, 66, 1'b1, 1'b1, 1'b1, 1'b0, have, e);
                if (have) begin
                    n_cmp++;
                    if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                        n_err++; $display("FAIL blink[f%0d.%0d]: got %h want %h", f, i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                    end
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        bit have; exp_t e;
        cur_x = 3'd7; cur_y = 3'd2;
        tick(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, have, e);
        for (int i = 0; i < 72; i++) begin
            tick(i * 9, 130, 1'b1, 1'b1, 1'b1, 1'b0, have, e);
            if (have) begin
                n_cmp++;
                if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                    n_err++; $display("FAIL oor_main[%0d]: got %h want %h", i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                end
                n_cmp++;
                if (color6 !== e.c6) begin
                    n_err++; $display("FAIL oor_cols6[%0d]: got %h want %h", i, color6, e.c6);
                end
                n_cmp++;
                if (color6 === C_CUR) begin
                    n_err++; $display("FAIL oor_no_cursor[%0d]: got %h want not %h", i, color6, C_CUR);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit have; exp_t e;
        for (int i = 0; i < 4; i++) tick(71 + i, 66, 1'b1, 1'b0, 1'b1, 1'b0, have, e);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (color !== 24'h0) begin n_err++; $display("FAIL midreset_color: got %h want 000000", color); end
        n_cmp++; if (hsync_o !== 1'b1) begin n_err++; $display("FAIL midreset_hsync: got %b want 1", hsync_o); end
        n_cmp++; if (pix_valid_o !== 1'b0) begin n_err++; $display("FAIL midreset_pv: got %b want 0", pix_valid_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        restart_after_reset();
        for (int i = 0; i < 6; i++) begin
            tick(i < 3 ? 71 : 20, i < 3 ? 66 : 20, 1'b1, 1'b0, 1'b1, 1'b0, have, e);
            if (have) begin
                n_cmp++;
                if ({color, pix_valid_o, hsync_o, vsync_o} !== e.main) begin
                    n_err++; $display("FAIL midreset_resume[%0d]: got %h want %h", i, {color, pix_valid_o, hsync_o, vsync_o}, e.main);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cell_mapping();
        test_syncs();
        test_cursor_latch();
        test_blink();
        test_out_of_range();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
- Parametrised, pipelined successor to the combinational board-cell colour generator.
- Maps each VGA pixel coordinate to a cell of a COLS x ROWS board.
- Looks up the cell state and selects a palette colour, with a latched, optionally blinking cursor.
- Sits between the VGA timing controller (x, y, syncs) and the DAC/colour output. Delays the syncs to stay aligned with the colour.

Parameters:
- COLS, 8, board columns (>=2)
- ROWS, 8, board rows (>=2)
- STATE_W, 4, bits per cell state
- X_OFF, 11, first pixel x of column 0
- Y_OFF, 6, first pixel y of row 0
- PITCH_X, 60, x distance between column origins
- PITCH_Y, 60, y distance between row origins
- CELL_W, 49, cell width in pixels (<= PITCH_X)
- CELL_H, 49, cell height in pixels (<= PITCH_Y)
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)
- COLOR_BG, 24'hffffff, colour outside cells
- COLOR_CUR, 24'h025e33, cursor colour
- COLOR_S0, 24'h4a004a, state 0 colour
- COLOR_S1, 24'hff0000, state 1 colour
- COLOR_S2, 24'h0000ff, state 2 colour
- COLOR_SX, 24'h4a004a, colour for states >=3

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- x, input, 10, current pixel column
- y, input, 10, current pixel row
- pix_valid, input, 1, pixel is in the visible area
- hsync_i, input, 1, horizontal sync from timing
- vsync_i, input, 1, vertical sync from timing
- frame_tick, input, 1, one-cycle pulse at start of vertical blanking
- cur_x, input, $clog2(COLS), requested cursor column
- cur_y, input, $clog2(ROWS), requested cursor row
- board, input, COLS*ROWS*STATE_W, cell (c,r) is at bits [(c*ROWS+r)*STATE_W +: STATE_W]
- color, output, 24, registered RGB
- pix_valid_o, output, 1, pix_valid delayed 2 cycles
- hsync_o, output, 1, hsync_i delayed 2 cycles
- vsync_o, output, 1, vsync_i delayed 2 cycles

Behaviour:
- Reset values (async, rst_n low):
  - color=0, pix_valid_o=0, hsync_o=1, vsync_o=1
  - latched cursor = (0,0), blink counter=0, blink phase=1 (visible)
  - all pipeline registers cleared; sync stages reset to 1
- Column hit: column c is hit when X_OFF+c*PITCH_X <= x <= X_OFF+c*PITCH_X+CELL_W-1. Row hit is analogous with Y_OFF, PITCH_Y and CELL_H.
  - Use a comparator per column/row. No dividers.
  - Intermediate arithmetic is 12 bits wide so it cannot overflow.
- Stage 1 (cycle 1) registers:
  - inside = column hit AND row hit
  - the hit column and row indices
  - pix_valid and the syncs
- Stage 2 (cycle 2) registers color:
  - pix_valid pipe=0 -> 24'h000000 (blanking)
  - else !inside -> COLOR_BG
  - else cell == latched cursor AND cursor visible -> COLOR_CUR
  - else the palette colour for the cell state: 0/1/2/>=3 -> S0/S1/S2/SX
- Latency: exactly 2 clk cycles from x/y/pix_valid/syncs to color/pix_valid_o/syncs_o. Throughput is 1 pixel per clock.
- board is sampled live in stage 2. Board updates mid-frame may tear; that is acceptable and documented.
- Cursor latch: cur_x and cur_y are captured only on frame_tick, so the cursor never moves mid-frame.
  - If the captured value differs from the current latch: blink counter <- 0 and phase <- 1, so a moved cursor shows immediately.
  - A latched cur_x >= COLS or cur_y >= ROWS means no cursor is drawn.
- Blink counter, on frame_tick with the cursor unchanged:
  - counter == BLINK_FRAMES-1 -> counter <- 0 and phase toggles
  - otherwise counter increments
  - BLINK_FRAMES=1 toggles the phase every frame.
- frame_tick asserted together with pix_valid: the latch and blink updates still apply. The pixel in flight uses the old cursor.
- Reset mid-frame: outputs take their reset values immediately. Normal output resumes 2 cycles after rst_n deasserts.

Optional Feature:
- Macro: GRID_RENDERER_CURSOR_BLINK_EN.
- Defined: blink counter and phase operate as specified above.
- Undefined: no blink logic is synthesised, the phase is constant 1 and the cursor is always visible. Cursor latching on frame_tick is unchanged.

Test Plan:
- Reset: rst_n low with x=20, y=20, pix_valid=1 -> color=0, hsync_o=1, vsync_o=1. After release, color=24'h4a004a (state 0) 2 cycles later.
- Cell mapping, board all 0 except cell (3,5)=2:
  - x=191, y=306 -> 24'h0000ff
  - x=190 -> COLOR_BG 24'hffffff
  - x=239 -> 24'h0000ff
  - x=240 -> 24'hffffff
- Latency/syncs: an hsync_i pulse of 96 cycles -> identical pulse on hsync_o delayed exactly 2 cycles. pix_valid=0 -> color=0.
- Cursor latch:
  - cur=(2,2) changed mid-frame -> no change until frame_tick.
  - After frame_tick, pixel (141,126) -> 24'h025e33.
- Blink (macro on, BLINK_FRAMES=2, cursor static):
  - cursor visible for frames 0-1, hidden (state colour) for frames 2-3, visible again at frame 4.
  - Moving the cursor at frame 3 -> visible at once.
- Out-of-range cursor: COLS=6 build with cur_x=7 -> no cell shows 24'h025e33.
